// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state type and memory word widths for the memory port arbiter
package mem_ctrl_pkg;
  typedef enum logic {SCRUB, RUN} arb_state_t;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 128;
  typedef logic [DATA_W-1:0] mem_word_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; the pointer moves just past each winner
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  logic [PW-1:0] ptr, nxt, k;
  // scanning from the farthest offset down lets the nearest requester win
  always_comb begin
    grant = '0;
    nxt = ptr;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = PW'((int'(ptr) + i) % N);
      if (req[k]) begin
        grant = '0;
        grant[k] = 1'b1;
        nxt = PW'((int'(ptr) + i + 1) % N);
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= '0;
    else if (advance) ptr <= nxt;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one memory port with tagged read returns
// and a zero-fill scrub after reset or init_start
module mem_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ENTRIES = 16,
  parameter int ADDR_W = mem_ctrl_pkg::ADDR_W,
  parameter int DATA_W = mem_ctrl_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init_start,
  output logic                      init_busy,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      mem_wen,
  output logic [ADDR_W-1:0]         mem_write_ptr,
  output logic [ADDR_W-1:0]         mem_read_ptr,
  output logic [DATA_W-1:0]         mem_in_data,
  input  logic [DATA_W-1:0]         mem_out_data
);
  import mem_ctrl_pkg::*;
  localparam int SW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  arb_state_t state, nstate;
  logic [SW-1:0] scrub_addr;
  logic [NUM_REQ-1:0] grant, rsp_tag;
  logic xfer, g_we, oor, rsp_pending, rsp_oor, unused_bad_addr;
  logic [ADDR_W-1:0] g_addr, wptr_q, rptr_q;
  logic [DATA_W-1:0] g_wdata, wdata_q;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk(clk),
    .reset(reset),
    .req(state == RUN ? req_valid : '0),
    .advance(xfer),
    .grant(grant)
  );
  always_comb begin
    g_we = 1'b0;
    g_addr = '0;
    g_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        g_we = req_we[i];
        g_addr = req_addr[i*ADDR_W +: ADDR_W];
        g_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
  end
  assign xfer = |grant;
  assign oor = 32'(g_addr) >= ENTRIES;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= SCRUB;
    else state <= nstate;
  always_comb
    nstate = state == SCRUB ? (scrub_addr == SW'(ENTRIES - 1) ? RUN : SCRUB) : (init_start ? SCRUB : RUN);
  // idle cycles replay the held pointers/data so the memory inputs never glitch
  always_comb begin
    init_busy = state == SCRUB;
    req_ready = grant;
    mem_wen = state == SCRUB ? !reset : xfer && g_we && !oor;
    mem_write_ptr = state == SCRUB ? ADDR_W'(scrub_addr) : (xfer && g_we ? g_addr : wptr_q);
    mem_in_data = state == SCRUB ? '0 : (xfer && g_we ? g_wdata : wdata_q);
    mem_read_ptr = xfer && !g_we ? g_addr : rptr_q;
    rsp_valid = rsp_pending ? rsp_tag : '0;
    rsp_data = rsp_oor ? '0 : mem_out_data;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      scrub_addr <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      wdata_q <= '0;
      rsp_pending <= 1'b0;
      rsp_tag <= '0;
      rsp_oor <= 1'b0;
      unused_bad_addr <= 1'b0;
    end else begin
      scrub_addr <= state == SCRUB && scrub_addr != SW'(ENTRIES - 1) ? scrub_addr + 1'b1 : '0;
      wptr_q <= mem_write_ptr;
      rptr_q <= mem_read_ptr;
      wdata_q <= mem_in_data;
      rsp_pending <= xfer && !g_we;
      rsp_tag <= grant;
      rsp_oor <= oor;
      unused_bad_addr <= unused_bad_addr || (xfer && oor);
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random traffic checked against a behavioural
// model of the arbiter plus a registered-output memory
module tb_mem_port_arbiter;
  localparam int NR = 4;
  localparam int EN = 16;
  logic clk = 0, reset = 1, init_start = 0;
  logic [NR-1:0] req_valid = '0, req_we = '0;
  logic [NR*16-1:0] req_addr = '0;
  logic [NR*128-1:0] req_wdata = '0;
  logic init_busy, mem_wen;
  logic [NR-1:0] req_ready, rsp_valid;
  logic [127:0] rsp_data, mem_in_data, mem_out_data;
  logic [15:0] mem_write_ptr, mem_read_ptr;
  logic [127:0] mem [EN];
  logic [127:0] ref_mem [EN];
  int n_checks = 0, n_fail = 0;
  bit m_scrub, exp_pend;
  int m_sc, m_rr, exp_tag;
  logic [127:0] exp_data;
  logic [15:0] m_rptr;
  logic [NR-1:0] hold;
  int waits [NR];

  mem_port_arbiter #(.NUM_REQ(NR), .ENTRIES(EN)) dut (
    .clk(clk),
    .reset(reset),
    .init_start(init_start),
    .init_busy(init_busy),
    .req_valid(req_valid),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .mem_wen(mem_wen),
    .mem_write_ptr(mem_write_ptr),
    .mem_read_ptr(mem_read_ptr),
    .mem_in_data(mem_in_data),
    .mem_out_data(mem_out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wen) mem[mem_write_ptr[3:0]] <= mem_in_data;
    mem_out_data <= mem[mem_read_ptr[3:0]];
  end

  for (genvar r = 0; r < NR; r++) begin : g_stable
    assert property (@(posedge clk) disable iff (reset)
      req_valid[r] && !req_ready[r] |=> req_valid[r] && $stable(req_we[r]) &&
        $stable(req_addr[r*16 +: 16]) && $stable(req_wdata[r*128 +: 128]))
      else $error("request %0d changed before ready", r);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_scrub = 1;
    m_sc = 0;
    m_rr = 0;
    exp_pend = 0;
    m_rptr = '0;
    hold = '0;
    for (int r = 0; r < NR; r++) waits[r] = 0;
  endtask

  task automatic check_reset();
    #1;
    check("rst_busy", init_busy, 1);
    check("rst_ready", req_ready, 0);
    check("rst_rsp", rsp_valid, 0);
    check("rst_wen", mem_wen, 0);
    check("rst_wptr", mem_write_ptr, 0);
    check("rst_rptr", mem_read_ptr, 0);
    check("rst_wdata", mem_in_data, 0);
  endtask

  task automatic set_req(input int r, input bit v, input bit w, input logic [15:0] a, input logic [127:0] d);
    req_valid[r] = v;
    req_we[r] = w;
    req_addr[r*16 +: 16] = a;
    req_wdata[r*128 +: 128] = d;
  endtask

  // one clock: compare the outputs of the current cycle, then advance the model
  task automatic cycle();
    int g = -1;
    int nt = 0;
    bit np = 0;
    logic [127:0] nd = '0;
    logic [15:0] a;
    logic [NR-1:0] ev = '0;
    logic [NR-1:0] er = '0;
    #1;
    if (exp_pend) er[exp_tag] = 1'b1;
    check("rsp_valid", rsp_valid, er);
    if (exp_pend) check("rsp_data", rsp_data, exp_data);
    if (m_scrub) begin
      check("scrub_busy", init_busy, 1);
      check("scrub_ready", req_ready, 0);
      check("scrub_wen", mem_wen, 1);
      check("scrub_wptr", mem_write_ptr, m_sc);
      check("scrub_wdata", mem_in_data, 0);
      check("scrub_rptr", mem_read_ptr, m_rptr);
      ref_mem[m_sc] = '0;
      hold = req_valid;
      m_scrub = m_sc != EN - 1;
      m_sc++;
    end else begin
      for (int k = 0; k < NR; k++)
        if (g < 0 && req_valid[(m_rr + k) % NR]) g = (m_rr + k) % NR;
      if (g >= 0) ev[g] = 1'b1;
      check("run_busy", init_busy, 0);
      check("grant", req_ready, ev);
      a = g >= 0 ? req_addr[g*16 +: 16] : '0;
      if (g >= 0 && req_we[g]) begin
        check("wen_write", mem_wen, a < EN);
        if (a < EN) begin
          check("wptr", mem_write_ptr, a);
          check("wdata", mem_in_data, req_wdata[g*128 +: 128]);
          ref_mem[a[3:0]] = req_wdata[g*128 +: 128];
        end
      end else begin
        check("wen_idle", mem_wen, 0);
        if (g >= 0) begin
          np = 1;
          nt = g;
          nd = a < EN ? ref_mem[a[3:0]] : '0;
          m_rptr = a;
        end
        check("rptr", mem_read_ptr, m_rptr);
      end
      if (g >= 0) begin
        check("wait_bound", waits[g] <= NR - 1, 1);
        m_rr = (g + 1) % NR;
      end
      for (int r = 0; r < NR; r++) waits[r] = (req_valid[r] && r != g) ? waits[r] + 1 : 0;
      hold = req_valid & ~ev;
      if (init_start) begin
        m_scrub = 1;
        m_sc = 0;
      end
    end
    exp_pend = np;
    exp_tag = nt;
    exp_data = nd;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && req_valid != 0; i++) begin
      for (int r = 0; r < NR; r++) if (!hold[r]) req_valid[r] = 1'b0;
      if (req_valid != 0) cycle();
    end
    check("drained", req_valid, 0);
  endtask

  task automatic drive_random();
    init_start = $urandom_range(0, 199) == 0;
    for (int r = 0; r < NR; r++)
      if (!hold[r])
        set_req(r, $urandom_range(0, 99) < 55, $urandom_range(0, 2) == 0,
                $urandom_range(0, 9) == 0 ? 16'($urandom_range(16, 40)) : 16'($urandom_range(0, EN - 1)),
                {$urandom, $urandom, $urandom, $urandom});
  endtask

  initial begin
    for (int i = 0; i < EN; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    model_reset();
    @(negedge clk);
    check_reset();
    @(negedge clk);
    reset = 0;
    repeat (EN) cycle();
    cycle();
    set_req(1, 1, 0, 9, '0);
    cycle();
    set_req(1, 0, 0, 9, '0);
    cycle();
    set_req(0, 1, 1, 3, {16{8'hAA}});
    cycle();
    set_req(0, 1, 0, 3, '0);
    cycle();
    set_req(0, 0, 0, 3, '0);
    #1 check("raw_data", rsp_data, {16{8'hAA}});
    cycle();
    for (int r = 0; r < NR; r++) set_req(r, 1, 0, 16'(r + 1), '0);
    repeat (12) cycle();
    drain();
    set_req(2, 1, 1, 4, {4{32'h1234_5678}});
    cycle();
    set_req(2, 1, 0, 20, '0);
    cycle();
    set_req(2, 1, 1, 20, {4{32'hdead_beef}});
    cycle();
    set_req(2, 1, 0, 4, '0);
    cycle();
    set_req(2, 0, 0, 4, '0);
    cycle();
    set_req(1, 1, 1, 5, {4{32'hcafe_f00d}});
    init_start = 1;
    cycle();
    init_start = 0;
    set_req(1, 0, 0, 5, '0);
    set_req(3, 1, 0, 5, '0);
    for (int i = 0; i < EN; i++) begin
      init_start = i == 5;
      cycle();
    end
    init_start = 0;
    drain();
    cycle();
    repeat (2000) begin
      drive_random();
      cycle();
    end
    init_start = 0;
    drain();
    repeat (EN + 1) cycle();
    set_req(0, 1, 0, 2, '0);
    cycle();
    reset = 1;
    req_valid = '0;
    model_reset();
    check_reset();
    @(negedge clk);
    check_reset();
    @(negedge clk);
    reset = 0;
    repeat (EN) cycle();
    set_req(3, 1, 0, 2, '0);
    cycle();
    set_req(3, 0, 0, 2, '0);
    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
